// File: rtl/line_follow_pkg.sv
// Shared types and constants for the line-follower steering controller:
// state encodings, sensor patterns {L,C,R}, motor direction and turn memory values.
package line_follow_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FORWARD    = 3'd1,
      ST_TURN_LEFT  = 3'd2,
      ST_TURN_RIGHT = 3'd3,
      ST_SEARCH     = 3'd4,
      ST_HALT       = 3'd5
   } state_t;

   localparam logic [2:0] PAT_NONE         = 3'b000;
   localparam logic [2:0] PAT_RIGHT        = 3'b001;
   localparam logic [2:0] PAT_CENTER       = 3'b010;
   localparam logic [2:0] PAT_CENTER_RIGHT = 3'b011;
   localparam logic [2:0] PAT_LEFT         = 3'b100;
   localparam logic [2:0] PAT_SPLIT        = 3'b101;
   localparam logic [2:0] PAT_LEFT_CENTER  = 3'b110;
   localparam logic [2:0] PAT_ALL          = 3'b111;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_REV = 1'b0;

   localparam logic LAST_LEFT  = 1'b0;
   localparam logic LAST_RIGHT = 1'b1;

endpackage

// File: rtl/line_follow_controller_pwm.sv
// Per-motor PWM generator: free-running period counter, duty/direction captured
// only at the period wrap so pulses are never truncated, plus an immediate force-off.
module motor_pwm
   import line_follow_pkg::*;
#(
   parameter logic [15:0] PWM_PERIOD = 16'd1000
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] i_duty,
   input  logic        i_dir,
   input  logic        i_forceOff,
   output logic        o_pwm,
   output logic        o_dir
);

   logic [15:0] r_cnt;
   logic [15:0] r_duty;
   logic        r_dirLatch;
   logic        r_dirOut;
   logic        r_pwm;
   logic        w_wrap;

   assign w_wrap = (r_cnt == PWM_PERIOD - 16'd1);

   // The direction pin is delayed one cycle so it switches together with the
   // first pulse of the new period rather than during the tail of the old one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt      <= 16'd0;
         r_duty     <= 16'd0;
         r_dirLatch <= DIR_FWD;
         r_dirOut   <= DIR_FWD;
         r_pwm      <= 1'b0;
      end else begin
         r_cnt    <= w_wrap ? 16'd0 : r_cnt + 16'd1;
         r_dirOut <= r_dirLatch;
         if (w_wrap) begin
            r_dirLatch <= i_dir;
         end
         if (i_forceOff) begin
            r_duty <= 16'd0;
            r_pwm  <= 1'b0;
         end else begin
            r_pwm <= (r_cnt < r_duty);
            if (w_wrap) begin
               r_duty <= i_duty;
            end
         end
      end
   end

   assign o_pwm = r_pwm;
   assign o_dir = r_dirOut;

endmodule

// File: rtl/line_follow_controller.sv
// Steering FSM for the line-follower: decodes the {L,C,R} sensor pattern into
// forward/turn/search/halt and commands two phase-aligned motor PWM generators.
module line_follow_controller
   import line_follow_pkg::*;
#(
   parameter logic [15:0] PWM_PERIOD     = 16'd1000,
   parameter logic [15:0] DUTY_FAST      = 16'd800,
   parameter logic [15:0] DUTY_SLOW      = 16'd300,
   parameter logic [23:0] SEARCH_TIMEOUT = 24'd5000000
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       sensor_left,
   input  logic       sensor_center,
   input  logic       sensor_right,
   output logic       motor_left_pwm,
   output logic       motor_right_pwm,
   output logic       motor_left_dir,
   output logic       motor_right_dir,
   output logic [2:0] state_out,
   output logic       lost
);

   state_t      r_state;
   logic        r_lastTurn;
   logic [23:0] r_searchCnt;
   logic        r_lost;

   logic [2:0]  w_pattern;
   logic [15:0] w_dutyLeft;
   logic [15:0] w_dutyRight;
   logic        w_dirLeft;
   logic        w_dirRight;
   logic        w_forceOff;

   assign w_pattern = {sensor_left, sensor_center, sensor_right};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_lastTurn  <= LAST_LEFT;
         r_searchCnt <= 24'd0;
         r_lost      <= 1'b0;
      end else begin
         r_lost <= (r_state == ST_HALT);
         if (!enable) begin
            r_state     <= ST_IDLE;
            r_searchCnt <= 24'd0;
         end else if (r_state != ST_HALT) begin
            case (w_pattern)
               PAT_CENTER, PAT_ALL: r_state <= ST_FORWARD;
               PAT_LEFT, PAT_LEFT_CENTER: begin
                  r_state    <= ST_TURN_LEFT;
                  r_lastTurn <= LAST_LEFT;
               end
               PAT_RIGHT, PAT_CENTER_RIGHT: begin
                  r_state    <= ST_TURN_RIGHT;
                  r_lastTurn <= LAST_RIGHT;
               end
               // A split line keeps the current heading; with no heading yet, drive on.
               PAT_SPLIT: begin
                  case (r_state)
                     ST_IDLE, ST_SEARCH:                      r_state <= ST_FORWARD;
                     ST_FORWARD, ST_TURN_LEFT, ST_TURN_RIGHT: r_state <= r_state;
                     default:                                 r_state <= ST_IDLE;
                  endcase
               end
               default: begin
                  if (r_state != ST_SEARCH) begin
                     r_state     <= ST_SEARCH;
                     r_searchCnt <= 24'd0;
                  end else if (r_searchCnt == SEARCH_TIMEOUT - 24'd1) begin
                     r_state <= ST_HALT;
                  end else if (r_searchCnt != 24'hFF_FFFF) begin
                     r_searchCnt <= r_searchCnt + 24'd1;
                  end
               end
            endcase
         end
      end
   end

   // Search spins in place toward the side where the line was last seen.
   always_comb begin
      w_dutyLeft  = 16'd0;
      w_dutyRight = 16'd0;
      w_dirLeft   = DIR_FWD;
      w_dirRight  = DIR_FWD;
      w_forceOff  = 1'b0;
      case (r_state)
         ST_FORWARD: begin
            w_dutyLeft  = DUTY_FAST;
            w_dutyRight = DUTY_FAST;
         end
         ST_TURN_LEFT: begin
            w_dutyLeft  = DUTY_SLOW;
            w_dutyRight = DUTY_FAST;
         end
         ST_TURN_RIGHT: begin
            w_dutyLeft  = DUTY_FAST;
            w_dutyRight = DUTY_SLOW;
         end
         ST_SEARCH: begin
            w_dutyLeft  = DUTY_SLOW;
            w_dutyRight = DUTY_SLOW;
            if (r_lastTurn == LAST_LEFT) begin
               w_dirLeft = DIR_REV;
            end else begin
               w_dirRight = DIR_REV;
            end
         end
         default: w_forceOff = 1'b1;
      endcase
   end

   motor_pwm #(.PWM_PERIOD(PWM_PERIOD)) u_pwmLeft (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_duty     (w_dutyLeft),
      .i_dir      (w_dirLeft),
      .i_forceOff (w_forceOff),
      .o_pwm      (motor_left_pwm),
      .o_dir      (motor_left_dir)
   );

   motor_pwm #(.PWM_PERIOD(PWM_PERIOD)) u_pwmRight (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_duty     (w_dutyRight),
      .i_dir      (w_dirRight),
      .i_forceOff (w_forceOff),
      .o_pwm      (motor_right_pwm),
      .o_dir      (motor_right_dir)
   );

   assign state_out = r_state;
   assign lost      = r_lost;

endmodule

// File: tb/tb_line_follow_controller.sv
// Self-checking bench for line_follow_controller with a short PWM period and
// search timeout: decode table through a scoreboard, then timed PWM/search/reset sequences.
module tb_line_follow_controller;

   localparam logic [15:0] P_PERIOD  = 16'd10;
   localparam logic [15:0] P_FAST    = 16'd8;
   localparam logic [15:0] P_SLOW    = 16'd3;
   localparam logic [23:0] P_TIMEOUT = 24'd20;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       sensorLeft = 1'b0;
   logic       sensorCenter = 1'b0;
   logic       sensorRight = 1'b0;
   logic       pwmLeft, pwmRight, dirLeft, dirRight, lost;
   logic [2:0] stateOut;

   always #5 clk = ~clk;

   line_follow_controller #(
      .PWM_PERIOD     (P_PERIOD),
      .DUTY_FAST      (P_FAST),
      .DUTY_SLOW      (P_SLOW),
      .SEARCH_TIMEOUT (P_TIMEOUT)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .enable          (enable),
      .sensor_left     (sensorLeft),
      .sensor_center   (sensorCenter),
      .sensor_right    (sensorRight),
      .motor_left_pwm  (pwmLeft),
      .motor_right_pwm (pwmRight),
      .motor_left_dir  (dirLeft),
      .motor_right_dir (dirRight),
      .state_out       (stateOut),
      .lost            (lost)
   );

   typedef enum {SIG_STATE, SIG_LOST, SIG_PWML, SIG_PWMR, SIG_DIRL, SIG_DIRR} sig_e;

   typedef struct {
      sig_e        sig;
      logic [31:0] exp;
      string       name;
   } sb_t;

   typedef struct {
      logic       en;
      logic [2:0] pat;
      logic [2:0] expState;
   } vec_t;

   sb_t  sbQ[$];
   vec_t vecs[17];
   int   vectors = 0;
   int   miscompares = 0;
   int   k = 0;
   int   hl, hr;

   function automatic logic [31:0] sample(sig_e s);
      case (s)
         SIG_STATE: return {29'd0, stateOut};
         SIG_LOST:  return {31'd0, lost};
         SIG_PWML:  return {31'd0, pwmLeft};
         SIG_PWMR:  return {31'd0, pwmRight};
         SIG_DIRL:  return {31'd0, dirLeft};
         default:   return {31'd0, dirRight};
      endcase
   endfunction

   task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, k, act, exp);
      end
   endtask

   task automatic checkNow(sig_e s, logic [31:0] exp, string name);
      compare(name, sample(s), exp);
   endtask

   task automatic expectNext(sig_e s, logic [31:0] exp, string name);
      sbQ.push_back('{sig: s, exp: exp, name: name});
   endtask

   // Everything queued before an edge is what the DUT must show after that edge.
   task automatic checkOutput();
      sb_t e;
      while (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         compare(e.name, sample(e.sig), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
      checkOutput();
   endtask

   task automatic runTo(int target);
      while (k < target) tick();
   endtask

   task automatic applyStimulus(logic en, logic [2:0] pat);
      enable       = en;
      sensorLeft   = pat[2];
      sensorCenter = pat[1];
      sensorRight  = pat[0];
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      tick();
      k = 0;
      checkNow(SIG_STATE, 0, "rstState");
      checkNow(SIG_PWML, 0, "rstPwmL");
      checkNow(SIG_PWMR, 0, "rstPwmR");
      checkNow(SIG_DIRL, 1, "rstDirL");
      checkNow(SIG_DIRR, 1, "rstDirR");
      checkNow(SIG_LOST, 0, "rstLost");
      rst_n = 1'b1;
   endtask

   // Counts high cycles of each pwm over one full period window.
   task automatic countWindow(output int cl, output int cr);
      cl = 0;
      cr = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cl += int'(pwmLeft);
         cr += int'(pwmRight);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 3'b010, 3'd1};
      vecs[1]  = '{1'b1, 3'b101, 3'd1};
      vecs[2]  = '{1'b1, 3'b110, 3'd2};
      vecs[3]  = '{1'b1, 3'b101, 3'd2};
      vecs[4]  = '{1'b1, 3'b011, 3'd3};
      vecs[5]  = '{1'b1, 3'b111, 3'd1};
      vecs[6]  = '{1'b1, 3'b100, 3'd2};
      vecs[7]  = '{1'b1, 3'b001, 3'd3};
      vecs[8]  = '{1'b0, 3'b010, 3'd0};
      vecs[9]  = '{1'b1, 3'b101, 3'd1};
      vecs[10] = '{1'b1, 3'b000, 3'd4};
      vecs[11] = '{1'b1, 3'b101, 3'd1};
      vecs[12] = '{1'b1, 3'b000, 3'd4};
      vecs[13] = '{1'b1, 3'b110, 3'd2};
      vecs[14] = '{1'b0, 3'b000, 3'd0};
      vecs[15] = '{1'b1, 3'b000, 3'd4};
      vecs[16] = '{1'b1, 3'b010, 3'd1};

      applyStimulus(1'b0, 3'b000);
      applyReset();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].en, vecs[i].pat);
         expectNext(SIG_STATE, {29'd0, vecs[i].expState}, $sformatf("decodeVec%0d", i));
         expectNext(SIG_LOST, 0, $sformatf("decodeLost%0d", i));
         tick();
      end

      // Forward from reset: first pulse follows the first wrap
      applyStimulus(1'b0, 3'b000);
      applyReset();
      applyStimulus(1'b1, 3'b010);
      expectNext(SIG_STATE, 1, "fwdEntry");
      tick();
      runTo(10);
      checkNow(SIG_PWML, 0, "preWrapPwmL");
      checkNow(SIG_PWMR, 0, "preWrapPwmR");
      tick();
      checkNow(SIG_PWML, 1, "firstPulseL");
      checkNow(SIG_PWMR, 1, "firstPulseR");
      checkNow(SIG_DIRL, 1, "fwdDirL");
      checkNow(SIG_DIRR, 1, "fwdDirR");
      runTo(20);
      countWindow(hl, hr);
      compare("fwdDutyL", hl, 8);
      compare("fwdDutyR", hr, 8);

      // Turn left mid-period: current period must finish at the old duty
      hl = 0;
      hr = 0;
      for (int i = 31; i <= 40; i++) begin
         if (i == 36) begin
            applyStimulus(1'b1, 3'b100);
            expectNext(SIG_STATE, 2, "turnLeftEntry");
         end
         tick();
         hl += int'(pwmLeft);
         hr += int'(pwmRight);
      end
      compare("noRuntL", hl, 8);
      compare("noRuntR", hr, 8);
      countWindow(hl, hr);
      compare("turnLeftDutyL", hl, 3);
      compare("turnLeftDutyR", hr, 8);

      // Turn right, then lose the line: search spins right, then halts
      applyStimulus(1'b1, 3'b001);
      expectNext(SIG_STATE, 3, "turnRightEntry");
      tick();
      applyStimulus(1'b1, 3'b000);
      expectNext(SIG_STATE, 4, "searchEntry");
      tick();
      runTo(60);
      countWindow(hl, hr);
      compare("searchDutyL", hl, 3);
      compare("searchDutyR", hr, 3);
      checkNow(SIG_DIRL, 1, "searchDirL");
      checkNow(SIG_DIRR, 0, "searchDirR");
      runTo(71);
      checkNow(SIG_STATE, 4, "searchLastCycle");
      tick();
      checkNow(SIG_STATE, 5, "haltEntry");
      checkNow(SIG_LOST, 0, "lostNotYet");
      tick();
      checkNow(SIG_LOST, 1, "lostRises");
      checkNow(SIG_PWML, 0, "haltPwmL");
      checkNow(SIG_PWMR, 0, "haltPwmR");
      applyStimulus(1'b1, 3'b010);
      runTo(80);
      countWindow(hl, hr);
      compare("haltQuietL", hl, 0);
      compare("haltQuietR", hr, 0);
      checkNow(SIG_STATE, 5, "haltSticky");
      checkNow(SIG_DIRR, 1, "haltDirR");

      // Leave HALT only through enable=0
      applyStimulus(1'b0, 3'b010);
      expectNext(SIG_STATE, 0, "haltDisable");
      expectNext(SIG_LOST, 1, "lostLagsState");
      tick();
      applyStimulus(1'b1, 3'b010);
      expectNext(SIG_STATE, 1, "reEnableFwd");
      expectNext(SIG_LOST, 0, "lostFalls");
      tick();

      // One-cycle disable while forward and mid-pulse
      runTo(101);
      checkNow(SIG_PWML, 1, "fwdPulseL");
      applyStimulus(1'b0, 3'b010);
      expectNext(SIG_STATE, 0, "fwdDisable");
      tick();
      applyStimulus(1'b1, 3'b010);
      expectNext(SIG_STATE, 1, "fwdReEnable");
      tick();
      checkNow(SIG_PWML, 0, "stopLatencyL");
      checkNow(SIG_PWMR, 0, "stopLatencyR");
      runTo(105);
      checkNow(SIG_PWML, 0, "dutyClearedL");
      checkNow(SIG_PWMR, 0, "dutyClearedR");
      runTo(111);
      checkNow(SIG_PWML, 1, "resumePulseL");

      // Line returns exactly on the timeout cycle: decode wins over HALT
      applyStimulus(1'b1, 3'b000);
      expectNext(SIG_STATE, 4, "search2Entry");
      tick();
      runTo(131);
      checkNow(SIG_STATE, 4, "search2Held");
      applyStimulus(1'b1, 3'b010);
      expectNext(SIG_STATE, 1, "timeoutTieFwd");
      tick();
      tick();
      checkNow(SIG_LOST, 0, "tieNoLost");

      // Reset at PWM count 5 with last_turn=right; afterwards search must spin left
      runTo(135);
      applyReset();
      applyStimulus(1'b1, 3'b000);
      expectNext(SIG_STATE, 4, "postRstSearch");
      tick();
      runTo(10);
      checkNow(SIG_PWML, 0, "postRstPreWrapL");
      tick();
      checkNow(SIG_PWML, 1, "postRstPulseL");
      checkNow(SIG_PWMR, 1, "postRstPulseR");
      checkNow(SIG_DIRL, 0, "postRstDirL");
      checkNow(SIG_DIRR, 1, "postRstDirR");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/line_follow_controller.md
# line_follow_controller

Steering controller for the line-follower bot. It consumes the three debounced light-sensor outputs (left, center, right) and sequences the robot through forward, turn, search and halt states. It drives both motors through per-motor PWM generators and direction lines. It sits between the sensor filters and the motor driver pins.

## Interface
Parameters:
- PWM_PERIOD, 16'd1000: PWM period in clk cycles; legal range 2..65535.
- DUTY_FAST, 16'd800: high cycles per period for the outer/straight motor.
- DUTY_SLOW, 16'd300: high cycles per period for the inner motor and for search spin.
- SEARCH_TIMEOUT, 24'd5000000: cycles spent in SEARCH before giving up.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous, active-low reset.
- enable, input, 1: run request; 0 forces IDLE.
- sensor_left / sensor_center / sensor_right, input, 1 each: filtered sensor, 1 = line seen.
- motor_left_pwm / motor_right_pwm, output, 1 each: PWM drive.
- motor_left_dir / motor_right_dir, output, 1 each: 1 = forward, 0 = reverse.
- state_out, output, 3: current state encoding.
- lost, output, 1: high while in HALT.

## Operation
- States: IDLE=0, FORWARD=1, TURN_LEFT=2, TURN_RIGHT=3, SEARCH=4, HALT=5. Encodings 6 and 7 go to IDLE.
- Reset (rst_n=0 at an edge) sets the following values:
  - state IDLE.
  - last_turn = left (0).
  - Search counter 0 and PWM counters 0.
  - All pwm outputs 0, all dir outputs 1, lost 0.
- enable=0 overrides everything: next state is IDLE from any state. The search counter clears.
- Pattern {L,C,R} is decoded each cycle when enable=1 and the state is not HALT:
  - 010 or 111 -> FORWARD.
  - 110 or 100 -> TURN_LEFT; set last_turn=left.
  - 011 or 001 -> TURN_RIGHT; set last_turn=right.
  - 101 -> stay in the current state. From IDLE or SEARCH it goes to FORWARD instead.
  - 000 -> SEARCH. On entry from any other state the search counter clears.
- SEARCH:
  - The counter increments each cycle while the pattern is 000.
  - When the counter reaches SEARCH_TIMEOUT-1 with pattern 000, the next state is HALT.
  - A nonzero pattern exits per the decode rules.
  - If a nonzero pattern coincides with the timeout cycle, the decode rules win.
- HALT: left only when enable=0.
- Motor command per state (duty, direction):
  - IDLE / HALT: both duty 0, dir 1.
  - FORWARD: both DUTY_FAST, dir 1.
  - TURN_LEFT: left DUTY_SLOW, right DUTY_FAST, dir 1.
  - TURN_RIGHT: mirror of TURN_LEFT.
  - SEARCH: spin toward last_turn. Inner motor dir 0, outer motor dir 1, both DUTY_SLOW.
- PWM generator:
  - Counter runs 0..PWM_PERIOD-1, then wraps to 0.
  - Output is registered: pwm = (cnt < duty_latched).
  - duty_latched and dir are captured only when the counter wraps to 0. No runt pulses; dir never changes mid-period.
  - duty 0 gives a constant 0. duty >= PWM_PERIOD gives a constant 1.
  - Exception: entry into IDLE or HALT forces duty_latched to 0 and pwm to 0 immediately, without waiting for the wrap.

## Timing
- Sensor pattern present before edge k -> state_out updates at edge k.
- The new duty and dir reach the pins at the first period wrap after edge k, plus one registered cycle.
- Worst-case command latency is PWM_PERIOD+1 cycles.
- Stop latency (enable=0, or entry into HALT) is 2 cycles to pwm=0.
- lost is registered from state and rises one cycle after state_out = 5.
- Search counter width is 24 bits and saturates; it never wraps.
- PWM counter width is 16 bits; both motor counters stay phase-aligned.
- Reset mid-period: counters restart at 0 and the outputs return to their reset values at that edge.

## Structure
- Package line_follow_pkg holds:
  - state encodings.
  - sensor-pattern constants (PAT_CENTER=3'b010, etc.).
  - Direction constants DIR_FWD=1 and DIR_REV=0.
- Sub-module motor_pwm: counter, duty/dir latch, force-off input. Instantiated once per motor.
- The FSM, last_turn register and search counter live in line_follow_controller.

## Test plan
All scenarios use PWM_PERIOD=10, DUTY_FAST=8, DUTY_SLOW=3, SEARCH_TIMEOUT=20.
- Reset then enable=1, pattern 010:
  - state_out=1 after 1 edge.
  - From the next wrap, both pwm are high 8 of every 10 cycles and both dir=1.
- Pattern 100 mid-period:
  - state_out=2 immediately.
  - The left duty change to 3/10 appears only after the wrap; no period shorter than 10.
- Pattern 001 then 000 held:
  - SEARCH spins right: right dir=0, left dir=1, both 3/10.
  - HALT after 20 cycles; lost=1 one cycle later and pwm=0.
- In SEARCH, pattern 000 for 19 cycles, then 010:
  - FORWARD, no HALT, lost stays 0.
- From FORWARD, enable=0 for 1 cycle:
  - state_out=0, pwm=0 within 2 cycles.
  - Re-enable with 010 returns to FORWARD.
- Assert rst_n=0 for 1 cycle at PWM count 5:
  - All outputs are at reset values on the next cycle.
  - PWM counters restart at 0; last_turn=left.
